// File: rtl/seq_sdiv_if.sv
// Operand/result handshake bundle for the iterative signed divider.
// master drives operands and accepts results; slave is the divider.
interface seq_sdiv_if #(
   parameter int WIDTH = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] dividend;
   logic [WIDTH-1:0] divisor;
   logic             mode;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] quotient;
   logic [WIDTH-1:0] remainder;
   logic             dbz;
   logic             ovf;

   modport master (
      output in_valid, dividend, divisor, mode, out_ready,
      input  in_ready, out_valid, quotient, remainder, dbz, ovf
   );

   modport slave (
      input  in_valid, dividend, divisor, mode, out_ready,
      output in_ready, out_valid, quotient, remainder, dbz, ovf
   );
endinterface

// File: rtl/seq_sdiv.sv
// Iterative signed divider: restoring unsigned division on operand
// magnitudes, one quotient bit per clock, then a single sign/rounding
// fix-up cycle. Divide-by-zero and most-negative/-1 are resolved in the
// fix-up cycle so latency is the same for every operand pair.
//
// state | meaning
// IDLE  | in_ready high, waiting for an operand pair
// CALC  | WIDTH restoring-division steps on the magnitudes
// FIX   | apply signs, floor correction and special cases; load outputs
// DONE  | result held until the consumer takes it
module seq_sdiv #(
   parameter int WIDTH = 8
) (
   input  logic        clk,
   input  logic        rst,
   seq_sdiv_if.slave   bus
);
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
   localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [WIDTH-1:0] MAX_VAL = ~MIN_VAL;

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

   state_t           state, state_nxt;
   logic             in_ready_c;
   logic             accept;
   logic [CW-1:0]    bit_cnt;

   logic [WIDTH-1:0] quo_sh;
   logic [WIDTH-1:0] rem_acc;
   logic [WIDTH-1:0] div_mag;
   logic [WIDTH-1:0] dvd_raw;
   logic [WIDTH-1:0] div_raw;
   logic             sign_a, sign_b, mode_r, dbz_f, ovf_f;

   logic [WIDTH-1:0] dvd_abs, div_abs;
   logic [WIDTH:0]   trial, diff;
   logic             q_neg;
   logic [WIDTH-1:0] q_fix, r_fix;

   logic             out_valid_r, dbz_r, ovf_r;
   logic [WIDTH-1:0] quotient_r, remainder_r;

   // Magnitudes as unsigned WIDTH bits, so |most-negative| = 2^(WIDTH-1) fits.
   assign dvd_abs = bus.dividend[WIDTH-1] ? (~bus.dividend + ONE) : bus.dividend;
   assign div_abs = bus.divisor[WIDTH-1]  ? (~bus.divisor + ONE)  : bus.divisor;

   // One restoring step: shift next dividend bit in, subtract if it fits.
   assign trial = {rem_acc, quo_sh[WIDTH-1]};
   assign diff  = trial - {1'b0, div_mag};

   assign accept = bus.in_valid && in_ready_c;

   // State register; reset wins over any handshake on the same edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state and in_ready decode.
   always_comb begin
      state_nxt  = state;
      in_ready_c = (state == S_IDLE) && !rst;
      case (state)
         S_IDLE: if (bus.in_valid && in_ready_c) state_nxt = S_CALC;
         S_CALC: if (bit_cnt == '0) state_nxt = S_FIX;
         S_FIX:  state_nxt = S_DONE;
         S_DONE: if (out_valid_r && bus.out_ready) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Operand capture on accept and the shift/subtract datapath during CALC.
   always_ff @(posedge clk) begin
      if (accept) begin
         quo_sh  <= dvd_abs;
         rem_acc <= '0;
         div_mag <= div_abs;
         dvd_raw <= bus.dividend;
         div_raw <= bus.divisor;
         sign_a  <= bus.dividend[WIDTH-1];
         sign_b  <= bus.divisor[WIDTH-1];
         mode_r  <= bus.mode;
         dbz_f   <= (bus.divisor == '0);
         ovf_f   <= (bus.dividend == MIN_VAL) && (bus.divisor == '1);
         bit_cnt <= CW'(WIDTH - 1);
      end else if (state == S_CALC) begin
         if (!diff[WIDTH]) begin
            rem_acc <= diff[WIDTH-1:0];
            quo_sh  <= {quo_sh[WIDTH-2:0], 1'b1};
         end else begin
            rem_acc <= trial[WIDTH-1:0];
            quo_sh  <= {quo_sh[WIDTH-2:0], 1'b0};
         end
         bit_cnt <= bit_cnt - CW'(1);
      end
   end

   // Sign application, floor correction and special-case override.
   always_comb begin
      q_neg = sign_a ^ sign_b;
      q_fix = q_neg  ? (~quo_sh + ONE)  : quo_sh;
      r_fix = sign_a ? (~rem_acc + ONE) : rem_acc;
      if (mode_r && q_neg && (rem_acc != '0)) begin
         q_fix = q_fix - ONE;
         r_fix = r_fix + div_raw;
      end
      if (dbz_f) begin
         q_fix = dvd_raw[WIDTH-1] ? MIN_VAL : MAX_VAL;
         r_fix = dvd_raw;
      end else if (ovf_f) begin
         q_fix = MAX_VAL;
         r_fix = '0;
      end
   end

   // Result registers: loaded in FIX, held through DONE, cleared by reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_r <= 1'b0;
         quotient_r  <= '0;
         remainder_r <= '0;
         dbz_r       <= 1'b0;
         ovf_r       <= 1'b0;
      end else if (state == S_FIX) begin
         out_valid_r <= 1'b1;
         quotient_r  <= q_fix;
         remainder_r <= r_fix;
         dbz_r       <= dbz_f;
         ovf_r       <= ovf_f && !dbz_f;
      end else if (out_valid_r && bus.out_ready) begin
         out_valid_r <= 1'b0;
      end
   end

   assign bus.in_ready  = in_ready_c;
   assign bus.out_valid = out_valid_r;
   assign bus.quotient  = quotient_r;
   assign bus.remainder = remainder_r;
   assign bus.dbz       = dbz_r;
   assign bus.ovf       = ovf_r;
endmodule

// File: tb/tb_seq_sdiv.sv
// Bench for seq_sdiv at WIDTH=8 and WIDTH=13: directed vectors with fixed
// expectations, backpressure, mid-operation reset, then a biased random
// sweep against an integer-arithmetic reference model.
module tb_seq_sdiv;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   seq_sdiv_if #(.WIDTH(8))  if8 ();
   seq_sdiv_if #(.WIDTH(13)) if13 ();

   seq_sdiv #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(if8.slave));
   seq_sdiv #(.WIDTH(13)) dut13 (.clk(clk), .rst(rst), .bus(if13.slave));

   int n_cmp = 0;
   int n_err = 0;

   typedef struct packed {
      logic [7:0] a, b;
      logic       m;
      logic [7:0] q, r;
      logic       d, o;
   } vec_t;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] wmask(input int w);
      return 32'((64'd1 << w) - 64'd1);
   endfunction

   // Reference: plain signed arithmetic on sign-extended operands.
   task automatic ref_div(input int w, input logic [31:0] a, input logic [31:0] b, input logic m,
                          output logic [31:0] q, output logic [31:0] r, output logic d, output logic o);
      longint sa, sb, qq, rr, mn, mx;
      mn = -(longint'(1) << (w - 1));
      mx = -mn - 1;
      sa = longint'(a & wmask(w));
      if (sa > mx) sa = sa - (longint'(1) << w);
      sb = longint'(b & wmask(w));
      if (sb > mx) sb = sb - (longint'(1) << w);
      d = 1'b0;
      o = 1'b0;
      if (sb == 0) begin
         d  = 1'b1;
         qq = (sa >= 0) ? mx : mn;
         rr = sa;
      end else if (sa == mn && sb == -1) begin
         o  = 1'b1;
         qq = mx;
         rr = 0;
      end else begin
         qq = sa / sb;
         rr = sa % sb;
         if (m && rr != 0 && ((sa < 0) != (sb < 0))) begin
            qq = qq - 1;
            rr = rr + sb;
         end
      end
      q = 32'(qq) & wmask(w);
      r = 32'(rr) & wmask(w);
   endtask

   task automatic drv(input int w, input logic v, input logic [31:0] a, input logic [31:0] b, input logic m);
      if (w == 8) begin
         if8.in_valid = v; if8.dividend = a[7:0]; if8.divisor = b[7:0]; if8.mode = m;
      end else begin
         if13.in_valid = v; if13.dividend = a[12:0]; if13.divisor = b[12:0]; if13.mode = m;
      end
   endtask

   task automatic set_rdy(input int w, input logic v);
      if (w == 8) if8.out_ready = v;
      else        if13.out_ready = v;
   endtask

   task automatic smp(input int w, output logic ov, output logic ir, output logic d, output logic o,
                      output logic [31:0] q, output logic [31:0] r);
      if (w == 8) begin
         ov = if8.out_valid; ir = if8.in_ready; d = if8.dbz; o = if8.ovf;
         q = 32'(if8.quotient); r = 32'(if8.remainder);
      end else begin
         ov = if13.out_valid; ir = if13.in_ready; d = if13.dbz; o = if13.ovf;
         q = 32'(if13.quotient); r = 32'(if13.remainder);
      end
   endtask

   task automatic do_op(input int w, input logic [31:0] a, input logic [31:0] b, input logic m,
                        input logic [31:0] eq, input logic [31:0] er, input logic ed, input logic eo,
                        input int hold);
      logic ov, ir, d, o;
      logic [31:0] q, r, q0, r0;
      int lat, waited;
      waited = 0;
      @(negedge clk);
      smp(w, ov, ir, d, o, q, r);
      while (!ir && waited < 50) begin
         @(negedge clk);
         smp(w, ov, ir, d, o, q, r);
         waited++;
      end
      check_val("in_ready_wait", 32'(ir), 32'd1);
      if (!ir) return;
      drv(w, 1'b1, a, b, m);
      @(posedge clk);
      #1 drv(w, 1'b0, $urandom, $urandom, 1'($urandom));
      lat = 0;
      ov  = 1'b0;
      while (!ov && lat < 40) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
         smp(w, ov, ir, d, o, q, r);
      end
      check_val("latency", 32'(lat), 32'(w + 1));
      check_val("quotient", q, eq);
      check_val("remainder", r, er);
      check_val("dbz", 32'(d), 32'(ed));
      check_val("ovf", 32'(o), 32'(eo));
      q0 = q;
      r0 = r;
      for (int h = 0; h < hold; h++) begin
         drv(w, 1'b1, $urandom, $urandom, 1'($urandom));
         @(posedge clk);
         @(negedge clk);
         smp(w, ov, ir, d, o, q, r);
         check_val("hold_valid", 32'(ov), 32'd1);
         check_val("hold_in_ready", 32'(ir), 32'd0);
         check_val("hold_quotient", q, q0);
         check_val("hold_remainder", r, r0);
      end
      if (hold == 0) drv(w, 1'b0, $urandom, $urandom, 1'($urandom));
      set_rdy(w, 1'b1);
      @(posedge clk);
      #1 set_rdy(w, 1'b0);
      @(negedge clk);
      smp(w, ov, ir, d, o, q, r);
      check_val("release_valid", 32'(ov), 32'd0);
      check_val("release_in_ready", 32'(ir), 32'd1);
      drv(w, 1'b0, $urandom, $urandom, 1'($urandom));
   endtask

   initial begin
      vec_t vecs[7];
      logic ov, ir, d, o, m;
      logic [31:0] q, r, a, b, eq, er;
      logic ed, eo;
      int sel;

      vecs[0] = '{8'h70, 8'hFD, 1'b0, 8'hDB, 8'h01, 1'b0, 1'b0};
      vecs[1] = '{8'h70, 8'hFD, 1'b1, 8'hDA, 8'hFE, 1'b0, 1'b0};
      vecs[2] = '{8'h50, 8'h00, 1'b0, 8'h7F, 8'h50, 1'b1, 1'b0};
      vecs[3] = '{8'h90, 8'h00, 1'b1, 8'h80, 8'h90, 1'b1, 1'b0};
      vecs[4] = '{8'h80, 8'hFF, 1'b0, 8'h7F, 8'h00, 1'b0, 1'b1};
      vecs[5] = '{8'h80, 8'hFF, 1'b1, 8'h7F, 8'h00, 1'b0, 1'b1};
      vecs[6] = '{8'h80, 8'h01, 1'b0, 8'h80, 8'h00, 1'b0, 1'b0};

      rst = 1'b1;
      drv(8, 1'b0, 0, 0, 1'b0);
      drv(13, 1'b0, 0, 0, 1'b0);
      set_rdy(8, 1'b0);
      set_rdy(13, 1'b0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      smp(8, ov, ir, d, o, q, r);
      check_val("rst_out_valid", 32'(ov), 32'd0);
      check_val("rst_in_ready_low", 32'(ir), 32'd0);
      check_val("rst_quotient", q, 32'd0);
      check_val("rst_remainder", r, 32'd0);
      rst = 1'b0;
      @(negedge clk);
      smp(8, ov, ir, d, o, q, r);
      check_val("post_rst_in_ready", 32'(ir), 32'd1);

      for (int i = 0; i < 7; i++) begin
         do_op(8, 32'(vecs[i].a), 32'(vecs[i].b), vecs[i].m, 32'(vecs[i].q), 32'(vecs[i].r),
               vecs[i].d, vecs[i].o, (i == 1) ? 5 : 0);
      end

      // Reset during CALC: result registers clear, block returns to IDLE.
      @(negedge clk);
      drv(8, 1'b1, 32'h70, 32'hFD, 1'b0);
      @(posedge clk);
      #1 drv(8, 1'b0, 0, 0, 1'b0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1 smp(8, ov, ir, d, o, q, r);
      check_val("midrst_in_ready_low", 32'(ir), 32'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      smp(8, ov, ir, d, o, q, r);
      check_val("midrst_out_valid", 32'(ov), 32'd0);
      check_val("midrst_quotient", q, 32'd0);
      check_val("midrst_remainder", r, 32'd0);
      check_val("midrst_dbz", 32'(d), 32'd0);
      check_val("midrst_ovf", 32'(o), 32'd0);
      check_val("midrst_in_ready", 32'(ir), 32'd1);

      for (int wi = 0; wi < 2; wi++) begin
         int w;
         w = (wi == 0) ? 8 : 13;
         for (int i = 0; i < 1800; i++) begin
            a   = $urandom;
            b   = $urandom;
            m   = 1'($urandom);
            sel = $urandom_range(0, 11);
            case (sel)
               0: b = 32'd0;
               1: b = 32'hFFFF_FFFF;
               2: a = 32'd1 << (w - 1);
               3: begin
                  a = 32'd1 << (w - 1);
                  b = ($urandom_range(0, 1) == 0) ? 32'd1 : 32'hFFFF_FFFF;
               end
               4: b = 32'($urandom_range(1, 3));
               default: ;
            endcase
            ref_div(w, a, b, m, eq, er, ed, eo);
            do_op(w, a, b, m, eq, er, ed, eo, $urandom_range(0, 2));
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
